// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron array.
// Pure declarations: no logic, no latency, no flow control.
package lif_pkg;

    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } lif_state_t;

    // Wide enough to hold the value REFRACT_STEPS; never narrower than one bit.
    function automatic int refr_cnt_w(input int steps);
        return (steps < 1) ? 1 : $clog2(steps + 1);
    endfunction

    // Clamps a + b to 2^width-1; operands are zero-extended values below 2^width.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int width);
        logic [32:0] s;
        logic [31:0] mx;
        s  = {1'b0, a} + {1'b0, b};
        mx = (32'd1 << width) - 32'd1;
        return (s > {1'b0, mx}) ? mx : s[31:0];
    endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// Strobe/current/threshold in, spike/refractory/membrane out for the neuron array.
// No latency of its own; no backpressure, the array consumes every step strobe.
interface lif_neuron_array_if #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 8
);
    logic                         step;
    logic                         clear;
    logic [N_NEURONS*WIDTH-1:0]   current;
    logic [WIDTH-1:0]             threshold;
    logic [N_NEURONS-1:0]         spike;
    logic [N_NEURONS-1:0]         refractory;
    logic [N_NEURONS*WIDTH-1:0]   membrane;

    modport master (
        output step, clear, current, threshold,
        input  spike, refractory, membrane
    );

    modport slave (
        input  step, clear, current, threshold,
        output spike, refractory, membrane
    );
endinterface

// File: rtl/lif_cell.sv
// One LIF neuron: leak, saturating integrate, threshold fire, refractory hold.
// Outputs update one clk after a step strobe; no backpressure, every strobe is consumed.
module lif_cell
    import lif_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRACT_STEPS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             clear,
    input  logic [WIDTH-1:0] current,
    input  logic [WIDTH-1:0] threshold,
    output logic             spike,
    output logic             refractory,
    output logic [WIDTH-1:0] membrane
);
    localparam int RC_W = refr_cnt_w(REFRACT_STEPS);

    lif_state_t        state;
    logic [RC_W-1:0]   refr_cnt;
    logic [31:0]       v_ext;
    logic [31:0]       leaked;
    logic [31:0]       sum;
    logic              fire;

    assign v_ext  = 32'(membrane);
    assign leaked = v_ext - (v_ext >> LEAK_SHIFT);
    assign sum    = sat_add(leaked, 32'(current), WIDTH);
    assign fire   = (sum >= 32'(threshold));

    assign refractory = (state == ST_REFRACTORY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INTEGRATE;
            refr_cnt <= '0;
            spike    <= 1'b0;
            membrane <= '0;
        end else if (clear) begin
            state    <= ST_INTEGRATE;
            refr_cnt <= '0;
            spike    <= 1'b0;
            membrane <= '0;
        end else if (step) begin
            case (state)
                ST_INTEGRATE: begin
                    if (fire) begin
                        spike    <= 1'b1;
                        membrane <= '0;
                        if (REFRACT_STEPS > 0) begin
                            refr_cnt <= RC_W'(REFRACT_STEPS);
                            state    <= ST_REFRACTORY;
                        end
                    end else begin
                        spike    <= 1'b0;
                        membrane <= sum[WIDTH-1:0];
                    end
                end
                ST_REFRACTORY: begin
                    // Input is ignored here; the step after leaving integrates again.
                    spike    <= 1'b0;
                    membrane <= '0;
                    refr_cnt <= refr_cnt - RC_W'(1);
                    if (refr_cnt == RC_W'(1))
                        state <= ST_INTEGRATE;
                end
                default: begin
                    state <= ST_INTEGRATE;
                    spike <= 1'b0;
                end
            endcase
        end else begin
            spike <= 1'b0;
        end
    end
endmodule

// File: rtl/lif_neuron_array.sv
// N independent LIF neurons sharing clk, step strobe, clear and threshold.
// Spike/membrane registered one clk after a step; no backpressure.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS     = 4,
    parameter int WIDTH         = 8,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRACT_STEPS = 2
) (
    input  logic               clk,
    input  logic               rst,
    lif_neuron_array_if.slave  bus
);
    logic [N_NEURONS-1:0]       spike_w;
    logic [N_NEURONS-1:0]       refr_w;
    logic [N_NEURONS*WIDTH-1:0] mem_w;

    for (genvar k = 0; k < N_NEURONS; k++) begin : g_cell
        lif_cell #(
            .WIDTH         (WIDTH),
            .LEAK_SHIFT    (LEAK_SHIFT),
            .REFRACT_STEPS (REFRACT_STEPS)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .step       (bus.step),
            .clear      (bus.clear),
            .current    (bus.current[k*WIDTH +: WIDTH]),
            .threshold  (bus.threshold),
            .spike      (spike_w[k]),
            .refractory (refr_w[k]),
            .membrane   (mem_w[k*WIDTH +: WIDTH])
        );
    end

    assign bus.spike      = spike_w;
    assign bus.refractory = refr_w;
    assign bus.membrane   = mem_w;
endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array with default parameters (N=4, WIDTH=8, shift 3, 2 refractory steps).
module tb_lif_neuron_array;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int LS = 3;
    localparam int RS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lif_neuron_array_if #(.N_NEURONS(N), .WIDTH(W)) ifc ();

    lif_neuron_array #(
        .N_NEURONS(N), .WIDTH(W), .LEAK_SHIFT(LS), .REFRACT_STEPS(RS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct {
        logic [N-1:0]   spk;
        logic [N-1:0]   refr;
        logic [N*W-1:0] mem;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_v[N];
    int m_cnt[N];
    bit m_refr[N];
    bit m_spk[N];
    int cur[N];
    int thr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_v[k] = 0; m_cnt[k] = 0; m_refr[k] = 1'b0; m_spk[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit stp, input bit clr);
        int s;
        for (int k = 0; k < N; k++) begin
            if (clr) begin
                m_v[k] = 0; m_cnt[k] = 0; m_refr[k] = 1'b0; m_spk[k] = 1'b0;
            end else if (!stp) begin
                m_spk[k] = 1'b0;
            end else if (!m_refr[k]) begin
                s = m_v[k] - (m_v[k] / (1 << LS)) + cur[k];
                if (s > 255) s = 255;
                if (s >= thr) begin
                    m_spk[k] = 1'b1; m_v[k] = 0; m_refr[k] = 1'b1; m_cnt[k] = RS;
                end else begin
                    m_spk[k] = 1'b0; m_v[k] = s;
                end
            end else begin
                m_spk[k] = 1'b0;
                m_cnt[k] = m_cnt[k] - 1;
                if (m_cnt[k] == 0) m_refr[k] = 1'b0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.spk[k]        = m_spk[k];
            e.refr[k]       = m_refr[k];
            e.mem[k*W +: W] = m_v[k][W-1:0];
        end
        return e;
    endfunction

    // Drive one cycle, predict its outcome, then compare one edge later.
    task automatic cycle(input bit stp, input bit clr);
        exp_t e;
        ifc.step  = stp;
        ifc.clear = clr;
        for (int k = 0; k < N; k++) ifc.current[k*W +: W] = cur[k][W-1:0];
        ifc.threshold = thr[W-1:0];
        model_step(stp, clr);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("spike", 32'(ifc.spike), 32'(e.spk));
            check("refr", 32'(ifc.refractory), 32'(e.refr));
            check("mem", 32'(ifc.membrane), 32'(e.mem));
        end
    endtask

    task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
        cur[0] = c0; cur[1] = c1; cur[2] = c2; cur[3] = c3;
    endtask

    int t1_mem[7]  = '{40, 75, 106, 0, 0, 0, 40};
    int t1_spk[7]  = '{0, 0, 0, 1, 0, 0, 0};
    int t1_refr[7] = '{0, 0, 0, 1, 1, 0, 0};
    int t2_mem[3]  = '{88, 77, 68};

    initial begin
        rst = 1'b1;
        ifc.step = 1'b0; ifc.clear = 1'b0; ifc.current = '0; ifc.threshold = 8'd128;
        thr = 128;
        set_cur(0, 0, 0, 0);
        model_reset();
        #12;
        check("rst_spike", 32'(ifc.spike), 32'd0);
        check("rst_refr", 32'(ifc.refractory), 32'd0);
        check("rst_mem", 32'(ifc.membrane), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Integrate, fire, refractory, resume
        set_cur(40, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 1'b0);
            check("t1_mem", 32'(ifc.membrane[7:0]), 32'(t1_mem[i]));
            check("t1_spk", 32'(ifc.spike[0]), 32'(t1_spk[i]));
            check("t1_refr", 32'(ifc.refractory[0]), 32'(t1_refr[i]));
        end

        // Leak from a preloaded 100
        set_cur(0, 0, 0, 0);
        cycle(1'b0, 1'b1);
        set_cur(0, 100, 0, 0);
        cycle(1'b1, 1'b0);
        set_cur(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            check("t2_mem", 32'(ifc.membrane[15:8]), 32'(t2_mem[i]));
            check("t2_spk", 32'(ifc.spike[1]), 32'd0);
        end

        // Saturation: 75 leaks to 66, plus 250 would wrap without clamping
        cycle(1'b0, 1'b1);
        set_cur(0, 0, 40, 0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("t3_pre", 32'(ifc.membrane[23:16]), 32'd75);
        set_cur(0, 0, 250, 0);
        cycle(1'b1, 1'b0);
        check("t3_spk", 32'(ifc.spike[2]), 32'd1);
        check("t3_mem", 32'(ifc.membrane[23:16]), 32'd0);

        // Strobe gating
        cycle(1'b0, 1'b1);
        set_cur(40, 0, 0, 0);
        cycle(1'b1, 1'b0);
        set_cur(200, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
        check("t4_hold", 32'(ifc.membrane[7:0]), 32'd40);
        cycle(1'b1, 1'b0);
        check("t4_fire", 32'(ifc.spike[0]), 32'd1);

        // Clear beats step
        cycle(1'b0, 1'b1);
        set_cur(0, 0, 0, 120);
        cycle(1'b1, 1'b0);
        set_cur(0, 0, 0, 50);
        cycle(1'b1, 1'b1);
        check("t5_mem", 32'(ifc.membrane[31:24]), 32'd0);
        check("t5_spk", 32'(ifc.spike), 32'd0);

        // Async reset while refractory and with a spike in flight
        set_cur(200, 0, 0, 0);
        cycle(1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_rst_refr", 32'(ifc.refractory), 32'd0);
        check("t5_rst_spk", 32'(ifc.spike), 32'd0);
        check("t5_rst_mem", 32'(ifc.membrane), 32'd0);
        model_reset();
        #1;
        rst = 1'b0;

        // Threshold zero fires every integrating step
        thr = 0;
        set_cur(0, 0, 0, 0);
        cycle(1'b1, 1'b0);
        check("thr0_spk", 32'(ifc.spike), 32'hF);
        thr = 128;

        // All four in parallel
        cycle(1'b0, 1'b1);
        set_cur(128, 128, 128, 128);
        cycle(1'b1, 1'b0);
        check("t6_spk1", 32'(ifc.spike), 32'hF);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("t6_refr_end", 32'(ifc.refractory), 32'h0);
        cycle(1'b1, 1'b0);
        check("t6_spk4", 32'(ifc.spike), 32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
